// File: rtl/sigdelay_prog_if.sv
// Sample-stream bundle for the programmable delay line: control, input
// strobe/data and delayed output/status, shared by source and delay block.
interface sigdelay_prog_if #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 9
);
    logic                        en;
    // One bit wider than the address so requests beyond the buffer are
    // representable and can be clamped and flagged.
    logic [ADDR_WIDTH:0]         delay;
    logic                        in_valid;
    logic [WIDTH*CHANNELS-1:0]   in_sample;
    logic                        out_valid;
    logic [WIDTH*CHANNELS-1:0]   out_sample;
    logic                        primed;
    logic                        dly_clamped;

    modport master (
        output en, delay, in_valid, in_sample,
        input  out_valid, out_sample, primed, dly_clamped
    );

    modport slave (
        input  en, delay, in_valid, in_sample,
        output out_valid, out_sample, primed, dly_clamped
    );
endinterface

// File: rtl/sigdelay_prog.sv
// Programmable multi-channel delay line. Packed samples go into a circular
// buffer and come back out d_lat accepted samples later; a FILL phase emits
// zeros until enough history exists. Delay 0 is a registered passthrough.
module sigdelay_prog #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    sigdelay_prog_if.slave   bus
);
    localparam int SW    = WIDTH * CHANNELS;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DMAX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    typedef enum logic [1:0] {SRC_ZERO, SRC_BYP, SRC_RAM} src_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0]   fill_cnt, fill_nxt;
    logic [ADDR_WIDTH-1:0]   d_lat, d_lat_nxt;

    logic [SW-1:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   d_eff_p0;
    logic                    restart_p0;
    logic [ADDR_WIDTH-1:0]   d_use_p0;
    logic [ADDR_WIDTH-1:0]   fill_use_p0;
    logic                    emit_real_p0;
    logic                    take_p0;
    logic [ADDR_WIDTH-1:0]   rd_addr_p0;

    logic                    vld_p1;
    src_t                    src_p1;
    logic                    clamp_p1;
    logic [SW-1:0]           rd_p1;
    logic [SW-1:0]           byp_p1;

    // Stage p0: resolve the delay and fill position this cycle's sample uses.
    // Leaving IDLE or a new effective delay restarts the fill at index 0 so
    // a coincident sample is already handled under the new delay.
    always_comb begin
        d_eff_p0     = (bus.delay > DMAX) ? {ADDR_WIDTH{1'b1}} : bus.delay[ADDR_WIDTH-1:0];
        restart_p0   = (state == IDLE) || (d_eff_p0 != d_lat);
        d_use_p0     = restart_p0 ? d_eff_p0 : d_lat;
        fill_use_p0  = restart_p0 ? '0 : fill_cnt;
        emit_real_p0 = (d_use_p0 == '0) || (!restart_p0 && state == RUN) ||
                       (fill_use_p0 == d_use_p0);
        take_p0      = bus.en && bus.in_valid;
        rd_addr_p0   = wr_ptr - d_use_p0;
    end

    // Next-state logic: disable parks everything at zero, otherwise advance
    // the write pointer and fill count on each accepted sample.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        fill_nxt   = fill_cnt;
        d_lat_nxt  = d_lat;
        if (!bus.en) begin
            state_nxt  = IDLE;
            wr_ptr_nxt = '0;
            fill_nxt   = '0;
        end else begin
            d_lat_nxt = d_use_p0;
            fill_nxt  = fill_use_p0;
            if (restart_p0) begin
                state_nxt = (d_eff_p0 == '0) ? RUN : FILL;
            end
            if (bus.in_valid) begin
                wr_ptr_nxt = wr_ptr + 1'b1;
                if (emit_real_p0) begin
                    state_nxt = RUN;
                end else begin
                    fill_nxt = fill_use_p0 + 1'b1;
                end
            end
        end
    end

    // Control registers and output-source select, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            d_lat    <= '0;
            vld_p1   <= 1'b0;
            src_p1   <= SRC_ZERO;
            clamp_p1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            fill_cnt <= fill_nxt;
            d_lat    <= d_lat_nxt;
            vld_p1   <= take_p0;
            clamp_p1 <= (bus.delay > DMAX);
            if (!bus.en) begin
                src_p1 <= SRC_ZERO;
            end else if (bus.in_valid) begin
                if (!emit_real_p0) begin
                    src_p1 <= SRC_ZERO;
                end else if (d_use_p0 == '0) begin
                    src_p1 <= SRC_BYP;
                end else begin
                    src_p1 <= SRC_RAM;
                end
            end
        end
    end

    // Stage p1: buffer write, registered read and passthrough capture. The
    // data path is unreset; the select above masks it to zero after reset.
    always_ff @(posedge clk) begin
        if (take_p0) begin
            mem[wr_ptr] <= bus.in_sample;
            rd_p1       <= mem[rd_addr_p0];
            byp_p1      <= bus.in_sample;
        end
    end

    // Output mux: zeros during fill/idle, else the bypass or buffer data.
    always_comb begin
        bus.out_sample = '0;
        case (src_p1)
            SRC_BYP: bus.out_sample = byp_p1;
            SRC_RAM: bus.out_sample = rd_p1;
            default: bus.out_sample = '0;
        endcase
    end

    assign bus.out_valid   = vld_p1;
    assign bus.primed      = (state == RUN);
    assign bus.dly_clamped = clamp_p1;

endmodule

// File: tb/tb_sigdelay_prog.sv
// Randomized bench for sigdelay_prog against a sample-history reference model.
module tb_sigdelay_prog;
    localparam int AW   = 4;
    localparam int DMAX = 2 ** AW - 1;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    sigdelay_prog_if #(.WIDTH(8), .CHANNELS(2), .ADDR_WIDTH(AW)) bus();

    sigdelay_prog #(.WIDTH(8), .CHANNELS(2), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: accepted-sample history and fill progress.
    logic [15:0] hist[$];
    bit          m_active;
    int          m_d;
    int          m_n;
    bit          m_real;
    logic        m_vld;
    logic [15:0] m_out;
    logic        m_clamp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_real = 0; m_d = 0; m_n = 0;
        m_vld = 0; m_out = '0; m_clamp = 0;
    endtask

    task automatic model_step(input logic e, input int dly, input logic v, input logic [15:0] s);
        int d;
        d = (dly > DMAX) ? DMAX : dly;
        m_clamp = (dly > DMAX);
        if (!e) begin
            m_active = 0; m_real = 0; m_vld = 0; m_out = '0;
        end else begin
            if (!m_active || d != m_d) begin
                m_active = 1; m_d = d; m_n = 0; m_real = (d == 0);
            end
            m_vld = v;
            if (v) begin
                hist.push_back(s);
                if (hist.size() > 64) void'(hist.pop_front());
                if (m_n >= m_d) begin
                    m_out  = hist[hist.size() - 1 - m_d];
                    m_real = 1;
                end else begin
                    m_out = '0;
                    m_n++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid",   32'(bus.out_valid),   32'(m_vld));
        chk("out_sample",  32'(bus.out_sample),  32'(m_out));
        chk("primed",      32'(bus.primed),      32'(m_active && m_real));
        chk("dly_clamped", 32'(bus.dly_clamped), 32'(m_clamp));
    endtask

    task automatic cycle(input logic e, input int dly, input logic v, input logic [15:0] s);
        @(negedge clk);
        bus.en = e; bus.delay = 5'(dly); bus.in_valid = v; bus.in_sample = s;
        @(posedge clk);
        model_step(e, dly, v, s);
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst = 1'b1;
        @(posedge clk);
        model_step(bus.en, int'(bus.delay), bus.in_valid, bus.in_sample);
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b0;
        bus.en = 1'b0; bus.delay = '0; bus.in_valid = 1'b0; bus.in_sample = '0;
        model_reset();

        // Held in reset: everything reads zero.
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Released with en low: strobes are ignored.
        for (int i = 0; i < 6; i++) cycle(1'b0, 4, 1'(i % 2), 16'($urandom));

        // Basic delay of 4, back-to-back strobes.
        for (int k = 0; k < 10; k++) cycle(1'b1, 4, 1'b1, {8'(8'h10 + k), 8'(k)});
        cycle(1'b1, 4, 1'b0, 16'h0);
        cycle(1'b1, 4, 1'b0, 16'h0);

        // Sparse strobes at delay 3.
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 4; j++) cycle(1'b1, 3, 1'b0, 16'($urandom));
            cycle(1'b1, 3, 1'b1, 16'(k));
        end

        // Clamped delay across the pointer wrap, then passthrough.
        for (int k = 0; k < 40; k++) cycle(1'b1, 20, 1'b1, 16'($urandom));
        for (int k = 0; k < 10; k++) cycle(1'b1, 0, 1'b1, 16'($urandom));

        // Delay change 6 -> 2 coincident with a strobe.
        for (int k = 0; k < 15; k++) cycle(1'b1, 6, 1'b1, 16'($urandom));
        for (int k = 0; k < 10; k++) cycle(1'b1, 2, 1'b1, 16'($urandom));

        // One-cycle disable with a concurrent strobe, then refill.
        cycle(1'b0, 2, 1'b1, 16'hdead);
        for (int k = 0; k < 8; k++) cycle(1'b1, 2, 1'b1, 16'($urandom));

        // Asynchronous reset while running with a clamped delay.
        for (int k = 0; k < 20; k++) cycle(1'b1, 18, 1'b1, 16'($urandom));
        async_reset();
        for (int k = 0; k < 20; k++) cycle(1'b1, 5, 1'b1, 16'($urandom));

        // Random soak: enable, delay and strobes all vary.
        begin
            int dly = 3;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 19) == 0) dly = int'($urandom_range(0, 20));
                cycle(1'($urandom_range(0, 29) != 0), dly,
                      1'($urandom_range(0, 3) != 0), 16'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
